fifo_mem_arbiter: RTL and testbench
===================================

FIFO_MEM_ARBITER -- requirements
Module: fifo_mem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 8, width of each data word.
REQ-002 The block SHALL have parameter ADDR_SIZE, default 4, memory address width; the memory depth is 2**ADDR_SIZE.
REQ-003 The block SHALL have parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, as follows:
- wclk  in  1  the single clock; all state updates on its rising edge.
- wrst  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have these ports:
- req  in  NUM_REQ  per-requester write request.
- req_data  in  NUM_REQ*DATA_SIZE  write data; requester i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- gnt  out  NUM_REQ  one-hot, combinational; gnt[i]=1 means requester i's word is written at this edge.
- flush  in  1  synchronous FIFO empty command.
- mem_wdata  out  DATA_SIZE  to memory wdata.
- mem_waddr  out  ADDR_SIZE  to memory waddr.
- mem_wclk_en  out  1  to memory wclk_en.
- mem_wfull  out  1  to memory wfull.
- mem_raddr  out  ADDR_SIZE  to memory raddr.
- mem_rdata  in  DATA_SIZE  from memory rdata (combinational read).
- rd_data  out  DATA_SIZE  equal to mem_rdata.
- rd_valid  out  1  head word available.
- rd_ready  in  1  consumer accepts the head word.
- count  out  ADDR_SIZE+1  number of stored words.
- full  out  1  count == 2**ADDR_SIZE.
- empty  out  1  count == 0.

Function
REQ-006 The block SHALL keep the write pointer wptr, the read pointer rptr and count as registers; mem_waddr=wptr and mem_raddr=rptr.
REQ-007 Pointers SHALL be ADDR_SIZE bits and wrap from 2**ADDR_SIZE-1 to 0 with no extra logic.
REQ-008 A write SHALL be accepted when these three hold: any req bit is 1, full=0 and flush=0. Otherwise gnt SHALL be all zero.
REQ-009 Arbitration SHALL be round-robin: starting from register prio, the lowest index i (prio, prio+1, ... modulo NUM_REQ) with req[i]=1 is granted.
REQ-010 After a grant to requester i, prio SHALL become (i+1) mod NUM_REQ. When there is no grant, prio SHALL hold its value.
REQ-011 On an accepted write the block SHALL drive these:
- mem_wclk_en=1.
- mem_wdata = requester i's slice.
- wptr increments at the edge.
REQ-012 When no write is accepted, mem_wclk_en SHALL be 0. mem_wdata is then don't-care.
REQ-013 mem_wfull SHALL equal full, giving the memory a second write guard.
REQ-014 rd_valid SHALL equal !empty. rd_data SHALL be the word at rptr, visible in the same cycle (zero-latency head).
REQ-015 A pop SHALL occur when rd_valid=1, rd_ready=1 and flush=0; rptr increments at the edge.
REQ-016 count SHALL change each edge as follows:
- write only: +1.
- pop only: -1.
- write and pop together: unchanged.
- neither: unchanged.
REQ-017 When full, a write SHALL be refused even if a pop occurs in the same cycle. Gnt stays 0 and count decrements.
REQ-018 When empty, a pop SHALL never occur. A write in that cycle makes rd_valid=1 from the next cycle.
REQ-019 Write-to-read latency SHALL be exactly 1 cycle.
REQ-020 flush=1 SHALL take priority over all other activity and cause these at the edge:
- rptr <= wptr.
- count <= 0.
- no grant.
- no pop.
- prio unchanged.
REQ-021 A requester not granted SHALL hold its req and req_data. The block SHALL never drop or duplicate a granted word.

Reset
REQ-022 With wrst=1 at an edge, the block SHALL set wptr=0, rptr=0, count=0 and prio=0; wrst overrides flush and all requests.
REQ-023 While wrst=1, gnt SHALL be 0 and mem_wclk_en SHALL be 0.
REQ-024 After wrst the outputs SHALL read empty=1, full=0 and rd_valid=0.
REQ-025 Memory contents SHALL NOT be cleared by reset. Reset mid-operation discards all stored words.

Verification
REQ-026 Single requester: req[0]=1 for 16 cycles (ADDR_SIZE=4), data 0x00..0x0F, rd_ready=0 -> 16 grants, then full=1, gnt=0, count=16, mem_wclk_en=0.
REQ-027 Round-robin: req=4'b1111 held, FIFO not full -> grant order 0,1,2,3,0,1,...; with req=4'b1010 -> grants 1,3,1,3.
REQ-028 Full plus pop: full, req[2]=1, rd_ready=1 -> gnt=0, count=15 next cycle, then gnt[2]=1 the following cycle with count back to 16.
REQ-029 Wrap-around: 40 writes interleaved with 40 pops, data = sequence number -> rd_data is in order 0..39; pointers wrap past 15 correctly.
REQ-030 Flush and reset:
- Flush with count=5 and req[1]=1 asserted together -> no grant, next cycle empty=1 and rptr=wptr.
- wrst asserted mid-burst -> count=0, prio=0 and no grants on the following edge.

Source files
------------

// File: rtl/fifo_mem_arbiter.sv
// rtl/fifo_mem_arbiter.sv - round-robin multi-requester write front end for an external FIFO memory
// Pointers and occupancy live here; the memory itself sits outside with a combinational read port.
module fifo_mem_arbiter #(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_SIZE = 4,
    parameter int NUM_REQ   = 4
) (
    input  logic                           wclk,
    input  logic                           wrst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
    output logic [NUM_REQ-1:0]             gnt,
    input  logic                           flush,
    output logic [DATA_SIZE-1:0]           mem_wdata,
    output logic [ADDR_SIZE-1:0]           mem_waddr,
    output logic                           mem_wclk_en,
    output logic                           mem_wfull,
    output logic [ADDR_SIZE-1:0]           mem_raddr,
    input  logic [DATA_SIZE-1:0]           mem_rdata,
    output logic [DATA_SIZE-1:0]           rd_data,
    output logic                           rd_valid,
    input  logic                           rd_ready,
    output logic [ADDR_SIZE:0]             count,
    output logic                           full,
    output logic                           empty
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_SIZE:0]   DEPTH   = (ADDR_SIZE+1)'(1 << ADDR_SIZE);
    localparam logic [ADDR_SIZE:0]   CNT_ONE = (ADDR_SIZE+1)'(1);
    localparam logic [ADDR_SIZE-1:0] PTR_ONE = ADDR_SIZE'(1);

    logic [ADDR_SIZE-1:0] r_wptr;
    logic [ADDR_SIZE-1:0] r_rptr;
    logic [ADDR_SIZE:0]   r_count;
    logic [PW-1:0]        r_prio;

    logic [PW-1:0]        w_gnt_idx;
    logic [PW-1:0]        w_next_prio;
    logic                 w_found;
    logic                 w_wr;
    logic                 w_pop;

    assign full      = (r_count == DEPTH);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rd_valid  = !empty;
    assign rd_data   = mem_rdata;
    assign mem_waddr = r_wptr;
    assign mem_raddr = r_rptr;
    assign mem_wfull = full;

    // Scan requesters starting at r_prio, wrapping modulo NUM_REQ; first hit wins.
    always_comb begin
        int idx;
        idx       = 0;
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(r_prio) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!w_found && req[idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = PW'(idx);
            end
        end
    end

    assign w_wr        = w_found && !full && !flush && !wrst;
    assign w_pop       = rd_valid && rd_ready && !flush && !wrst;
    assign gnt         = w_wr ? (NUM_REQ'(1) << w_gnt_idx) : '0;
    assign mem_wclk_en = w_wr;
    assign mem_wdata   = req_data[int'(w_gnt_idx)*DATA_SIZE +: DATA_SIZE];
    assign w_next_prio = (w_gnt_idx == PW'(NUM_REQ-1)) ? '0 : w_gnt_idx + PW'(1);

    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_prio  <= '0;
        end else if (flush) begin
            r_rptr  <= r_wptr;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PTR_ONE;
                r_prio <= w_next_prio;
            end
            if (w_pop) r_rptr <= r_rptr + PTR_ONE;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_mem_arbiter.sv
// tb/tb_fifo_mem_arbiter.sv - randomized bench for fifo_mem_arbiter against a queue-based reference
// The bench owns the external memory array and a word-level model of the FIFO contents.
module tb_fifo_mem_arbiter;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NR = 4;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            wrst;
    logic [NR-1:0]   req;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   gnt;
    logic            flush;
    logic [DW-1:0]   mem_wdata;
    logic [AW-1:0]   mem_waddr;
    logic            mem_wclk_en;
    logic            mem_wfull;
    logic [AW-1:0]   mem_raddr;
    logic [DW-1:0]   mem_rdata;
    logic [DW-1:0]   rd_data;
    logic            rd_valid;
    logic            rd_ready;
    logic [AW:0]     count;
    logic            full;
    logic            empty;

    fifo_mem_arbiter #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .NUM_REQ(NR)) dut (
        .wclk(clk), .wrst(wrst), .req(req), .req_data(req_data), .gnt(gnt),
        .flush(flush), .mem_wdata(mem_wdata), .mem_waddr(mem_waddr),
        .mem_wclk_en(mem_wclk_en), .mem_wfull(mem_wfull), .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) if (mem_wclk_en && !mem_wfull) mem[mem_waddr] <= mem_wdata;
    assign mem_rdata = mem[mem_raddr];

    int n_vec = 0;
    int n_bad = 0;

    logic [DW-1:0] q [$];
    logic [DW-1:0] dat [NR];
    int m_wptr, m_rptr, m_prio, last_g;
    logic [DW-1:0] seq;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic [NR-1:0] r, input logic rr, input logic fl, input logic rs);
        int g;
        logic do_pop;
        @(negedge clk);
        req = r; rd_ready = rr; flush = fl; wrst = rs;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = dat[i];
        #1;
        g = -1;
        if (!rs && !fl && r != '0 && q.size() < DEPTH)
            for (int k = 0; k < NR; k++)
                if (g < 0 && r[(m_prio + k) % NR]) g = (m_prio + k) % NR;
        check_val("gnt", 32'(gnt), (g >= 0) ? 32'(1 << g) : 32'd0);
        check_val("wclk_en", 32'(mem_wclk_en), 32'(g >= 0));
        if (g >= 0) check_val("wdata", 32'(mem_wdata), 32'(dat[g]));
        check_val("waddr", 32'(mem_waddr), 32'(m_wptr));
        check_val("count", 32'(count), 32'(q.size()));
        check_val("empty", 32'(empty), 32'(q.size() == 0));
        check_val("full", 32'(full), 32'(q.size() == DEPTH));
        check_val("wfull", 32'(mem_wfull), 32'(q.size() == DEPTH));
        check_val("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check_val("raddr", 32'(mem_raddr), 32'(m_rptr));
            check_val("rd_data", 32'(rd_data), 32'(q[0]));
        end
        last_g = g;
        if (rs) begin
            q.delete(); m_wptr = 0; m_rptr = 0; m_prio = 0;
        end else if (fl) begin
            q.delete(); m_rptr = m_wptr;
        end else begin
            do_pop = (q.size() != 0) && rr;
            if (do_pop) begin
                void'(q.pop_front());
                m_rptr = (m_rptr + 1) % DEPTH;
            end
            if (g >= 0) begin
                q.push_back(dat[g]);
                m_wptr = (m_wptr + 1) % DEPTH;
                m_prio = (g + 1) % NR;
                dat[g] = seq;
                seq = seq + 8'd1;
            end
        end
    endtask

    initial begin
        logic [NR-1:0] rq;
        int pct;
        req = '0; req_data = '0; flush = 1'b0; rd_ready = 1'b0; wrst = 1'b1;
        seq = 8'd0;
        for (int i = 0; i < NR; i++) begin dat[i] = seq; seq = seq + 8'd1; end
        m_wptr = 0; m_rptr = 0; m_prio = 0; last_g = -1;
        repeat (2) @(posedge clk);

        // Single requester fills the FIFO, then is refused at full.
        for (int i = 0; i < 18; i++) step(4'b0001, 1'b0, 1'b0, 1'b0);
        // Full with a concurrent pop: refused, then granted next cycle.
        step(4'b0100, 1'b1, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        // Flush at count 5 with a pending request.
        step(4'b0000, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(4'b0001, 1'b0, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        // Round-robin sweeps.
        for (int i = 0; i < 12; i++) step(4'b1111, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(4'b1010, 1'b1, 1'b0, 1'b0);
        // Sustained write/pop streaming across pointer wrap.
        for (int i = 0; i < 45; i++) step(4'b0001, 1'b1, 1'b0, 1'b0);
        // Reset mid-burst.
        for (int i = 0; i < 4; i++) step(4'b1111, 1'b0, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, 1'b0, 1'b0);

        rq = '0;
        pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) pct = $urandom_range(90, 5);
            for (int i = 0; i < NR; i++)
                if (!(rq[i] && last_g != i)) rq[i] = ($urandom_range(99, 0) < 45);
            step(rq, ($urandom_range(99, 0) < pct), ($urandom_range(63, 0) == 0),
                 ($urandom_range(499, 0) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
